wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port among the four EXE units (ALU, LD, MUL, DIV).

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_prio_pick.sv | 16 +
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Unit indices double as bit positions in the per-unit request/busy vectors.
package wb_pkg;

  typedef enum logic [1:0] {
    UNIT_DIV = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_LD  = 2'd2,
    UNIT_ALU = 2'd3
  } unit_e;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

  // Encodes a one-hot unit mask; an empty mask maps to UNIT_DIV.
  function automatic unit_e onehot_idx(input logic [3:0] oh);
    unit_e u;
    u = UNIT_DIV;
    if (oh[UNIT_ALU])      u = UNIT_ALU;
    else if (oh[UNIT_LD])  u = UNIT_LD;
    else if (oh[UNIT_MUL]) u = UNIT_MUL;
    return u;
  endfunction

endpackage

// File: rtl/wb_prio_pick.sv
// Fixed-priority one-hot picker over the four EXE units: ALU > LD > MUL > DIV.
module wb_prio_pick (
  input  logic [3:0] req,
  output logic [3:0] gnt
);
  import wb_pkg::*;

  always_comb begin
    gnt = '0;
    if (req[UNIT_ALU])      gnt[UNIT_ALU] = 1'b1;
    else if (req[UNIT_LD])  gnt[UNIT_LD]  = 1'b1;
    else if (req[UNIT_MUL]) gnt[UNIT_MUL] = 1'b1;
    else if (req[UNIT_DIV]) gnt[UNIT_DIV] = 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port among ALU/LD/MUL/DIV with 1-entry slots
// and same-Rd ordering. Define WB_STARVE_GUARD_EN to add per-slot age counters.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int RD_W     = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_valid,
  input  logic [RD_W-1:0]   alu_rd,
  input  logic [RD_W-1:0]   ld_rd,
  input  logic [RD_W-1:0]   mul_rd,
  input  logic [RD_W-1:0]   div_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] mul_data,
  input  logic [DATA_W-1:0] div_data,
  output logic [3:0]        req_ready,
  output logic [3:0]        busy,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        wb_src
);
  import wb_pkg::*;

  logic [3:0]        busy_q;
  logic [RD_W-1:0]   rd_q     [4];
  logic [DATA_W-1:0] data_q   [4];
  logic [RD_W-1:0]   req_rd   [4];
  logic [DATA_W-1:0] req_data [4];
  logic [3:0]        busy_gnt;
  logic [3:0]        grant;
  logic [3:0]        waw;
  logic [3:0]        accept;
  unit_e             gidx;

  assign req_rd[UNIT_ALU]   = alu_rd;
  assign req_rd[UNIT_LD]    = ld_rd;
  assign req_rd[UNIT_MUL]   = mul_rd;
  assign req_rd[UNIT_DIV]   = div_rd;
  assign req_data[UNIT_ALU] = alu_data;
  assign req_data[UNIT_LD]  = ld_data;
  assign req_data[UNIT_MUL] = mul_data;
  assign req_data[UNIT_DIV] = div_data;

  wb_prio_pick u_busy_pick (.req(busy_q), .gnt(busy_gnt));

`ifdef WB_STARVE_GUARD_EN
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic [AGE_W-1:0] age_q [4];
  logic [3:0]       aged;
  logic [3:0]       aged_gnt;

  always_comb begin
    aged = '0;
    for (int i = 0; i < 4; i++)
      aged[i] = busy_q[i] && (age_q[i] == AGE_W'(MAX_WAIT));
  end

  wb_prio_pick u_aged_pick (.req(aged), .gnt(aged_gnt));

  // A slot that has waited MAX_WAIT cycles overrides fixed priority.
  assign grant = (|aged) ? aged_gnt : busy_gnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || grant[i])
        age_q[i] <= '0;
      else if (busy_q[i] && (age_q[i] != AGE_W'(MAX_WAIT)))
        age_q[i] <= age_q[i] + 1'b1;
    end
  end
`else
  assign grant = busy_gnt;
`endif

  assign gidx = onehot_idx(grant);

  // Higher-priority units are resolved first so a lower unit sees their accepts
  // and defers on a matching Rd, keeping same-Rd writes in accept order.
  always_comb begin
    waw       = '0;
    accept    = '0;
    req_ready = '0;
    for (int i = 3; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (j != i) begin
          if (busy_q[j] && !grant[j] && (rd_q[j] == req_rd[i])) waw[i] = 1'b1;
          if ((j > i) && accept[j] && (req_rd[j] == req_rd[i])) waw[i] = 1'b1;
        end
      end
      req_ready[i] = (!busy_q[i] || grant[i]) && !waw[i];
      accept[i]    = req_valid[i] && req_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= accept | (busy_q & ~grant);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        rd_q[i]   <= req_rd[i];
        data_q[i] <= req_data[i];
      end
    end
  end

  // Writeback stage: one granted slot per cycle drives the register-file port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_src  <= '0;
    end else begin
      wb_en <= |grant;
      if (|grant) begin
        wb_rd   <= rd_q[gidx];
        wb_data <= data_q[gidx];
        wb_src  <= gidx;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; expectations are hand-computed per step.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam int MAX_WAIT = 3;
`else
  localparam int MAX_WAIT = 8;
`endif

  logic              clk;
  logic              rst;
  logic [3:0]        req_valid;
  logic [RD_W-1:0]   alu_rd, ld_rd, mul_rd, div_rd;
  logic [DATA_W-1:0] alu_data, ld_data, mul_data, div_data;
  logic [3:0]        req_ready;
  logic [3:0]        busy;
  logic              wb_en;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        wb_src;

  int checks;
  int failures;

  wb_port_arbiter #(.DATA_W(DATA_W), .RD_W(RD_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .alu_rd(alu_rd), .ld_rd(ld_rd), .mul_rd(mul_rd), .div_rd(div_rd),
    .alu_data(alu_data), .ld_data(ld_data), .mul_data(mul_data), .div_data(div_data),
    .req_ready(req_ready), .busy(busy), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_src(wb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [RD_W-1:0] rd,
                        input logic [DATA_W-1:0] data, input logic [1:0] src);
    chk({tag, ".en"}, 32'(wb_en), 32'd1);
    chk({tag, ".rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".data"}, wb_data, data);
    chk({tag, ".src"}, 32'(wb_src), 32'(src));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    alu_rd = '0; ld_rd = '0; mul_rd = '0; div_rd = '0;
    alu_data = '0; ld_data = '0; mul_data = '0; div_data = '0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.ready", 32'(req_ready), 32'hF);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_src", 32'(wb_src), 32'd0);

    // All four units at once, drained in priority order
    req_valid = 4'b1111;
    alu_rd = 4'd1; ld_rd = 4'd2; mul_rd = 4'd3; div_rd = 4'd4;
    alu_data = 32'hA1; ld_data = 32'hA2; mul_data = 32'hA3; div_data = 32'hA4;
    #1 chk("all.ready", 32'(req_ready), 32'hF);
    tick();
    chk("all.busy0", 32'(busy), 32'hF);
    chk("all.en0", 32'(wb_en), 32'd0);
    req_valid = 4'b0000;
    tick(); chk_wb("all.w1", 4'd1, 32'hA1, 2'd3);
    chk("all.busy1", 32'(busy), 32'h7);
    tick(); chk_wb("all.w2", 4'd2, 32'hA2, 2'd2);
    tick(); chk_wb("all.w3", 4'd3, 32'hA3, 2'd1);
    tick(); chk_wb("all.w4", 4'd4, 32'hA4, 2'd0);
    chk("all.busy4", 32'(busy), 32'h0);
    tick(); chk("all.idle", 32'(wb_en), 32'd0);

    // LD back-to-back
    req_valid = 4'b0100; ld_rd = 4'd5; ld_data = 32'h55;
    #1 chk("ld.ready0", 32'(req_ready[2]), 32'd1);
    tick();
    chk("ld.busy", 32'(busy), 32'h4);
    ld_rd = 4'd6; ld_data = 32'h66;
    #1 chk("ld.ready1", 32'(req_ready[2]), 32'd1);
    tick(); chk_wb("ld.w5", 4'd5, 32'h55, 2'd2);
    ld_rd = 4'd7; ld_data = 32'h77;
    #1 chk("ld.ready2", 32'(req_ready[2]), 32'd1);
    tick(); chk_wb("ld.w6", 4'd6, 32'h66, 2'd2);
    req_valid = 4'b0000;
    tick(); chk_wb("ld.w7", 4'd7, 32'h77, 2'd2);
    tick(); chk("ld.idle", 32'(wb_en), 32'd0);

    // WAW: ALU and MUL both targeting r9
    req_valid = 4'b1010; alu_rd = 4'd9; alu_data = 32'h11; mul_rd = 4'd9; mul_data = 32'h22;
    #1 chk("waw.alu_ready", 32'(req_ready[3]), 32'd1);
    chk("waw.mul_ready", 32'(req_ready[1]), 32'd0);
    tick();
    chk("waw.busy", 32'(busy), 32'h8);
    chk("waw.en0", 32'(wb_en), 32'd0);
    req_valid = 4'b0010;
    #1 chk("waw.mul_ready2", 32'(req_ready[1]), 32'd1);
    tick(); chk_wb("waw.w1", 4'd9, 32'h11, 2'd3);
    chk("waw.busy2", 32'(busy), 32'h2);
    req_valid = 4'b0000;
    tick(); chk_wb("waw.w2", 4'd9, 32'h22, 2'd1);
    tick(); chk("waw.idle", 32'(wb_en), 32'd0);

    // DIV pending under continuous ALU traffic
    req_valid = 4'b1001; alu_rd = 4'd11; alu_data = 32'h30; div_rd = 4'd10; div_data = 32'hD0;
    tick();
    chk("stv.busy", 32'(busy), 32'h9);
    req_valid = 4'b1000;
    #1 chk("stv.div_ready", 32'(req_ready[0]), 32'd0);
`ifdef WB_STARVE_GUARD_EN
    for (int k = 0; k < 3; k++) begin
      tick(); chk_wb("stv.alu", 4'd11, 32'h30, 2'd3);
    end
    chk("stv.alu_blocked", 32'(req_ready[3]), 32'd0);
    tick(); chk_wb("stv.div", 4'd10, 32'hD0, 2'd0);
    req_valid = 4'b0000;
    tick(); chk_wb("stv.alu_last", 4'd11, 32'h30, 2'd3);
`else
    for (int k = 0; k < 4; k++) begin
      alu_data = 32'h31 + 32'(k);
      tick(); chk_wb("stv.alu", 4'd11, 32'h30 + 32'(k), 2'd3);
    end
    req_valid = 4'b0000;
    tick(); chk_wb("stv.alu_last", 4'd11, 32'h34, 2'd3);
    tick(); chk_wb("stv.div", 4'd10, 32'hD0, 2'd0);
`endif
    tick(); chk("stv.idle", 32'(wb_en), 32'd0);

    // Reset with all slots occupied discards them
    req_valid = 4'b1111;
    alu_rd = 4'd12; ld_rd = 4'd13; mul_rd = 4'd14; div_rd = 4'd15;
    alu_data = 32'hB1; ld_data = 32'hB2; mul_data = 32'hB3; div_data = 32'hB4;
    tick();
    chk("mrst.busy_full", 32'(busy), 32'hF);
    req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.busy", 32'(busy), 32'h0);
    chk("mrst.en", 32'(wb_en), 32'd0);
    chk("mrst.wb_rd", 32'(wb_rd), 32'd0);
    chk("mrst.wb_data", wb_data, 32'd0);
    chk("mrst.ready", 32'(req_ready), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick(); chk("mrst.no_write", 32'(wb_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
